// File: rtl/display_scan_counter_pkg.sv
// ============================================================================
//  disp_pkg
//  Shared types and helpers for the multiplexed seven-segment display scanner.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Active-high one-hot digit pattern for a 2-bit digit index.
    function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_counter_prescaler.sv
// ============================================================================
//  scan_prescaler
//  Divides the system clock down to a one-cycle tick every DIV_MAX enabled clocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module scan_prescaler #(
    parameter int DIV_MAX = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              c_dw       = $clog2(DIV_MAX);
    localparam logic [c_dw-1:0] c_div_last = c_dw'(DIV_MAX - 1);

    logic [c_dw-1:0] div_cnt_q;
    logic [c_dw-1:0] div_cnt_d;
    logic            w_at_last;

    assign w_at_last = (div_cnt_q == c_div_last);
    // A frozen counter parked on its last value must not fire while disabled.
    assign tick      = enable && w_at_last;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (enable) begin
            div_cnt_d = w_at_last ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_counter.sv
// ============================================================================
//  display_scan_counter
//  Digit index and anode scanner for a 4-digit multiplexed display, with a
//  blanking gap after every digit change.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_counter
    import disp_pkg::*;
#(
    parameter int DIV_MAX          = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       saida1Contador,
    output logic       saida2Contador,
    output logic [3:0] anode,
    output logic       frame_done
);

    localparam int              c_bw         = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [c_bw-1:0] c_blank_last = c_bw'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    generate
        if (DIV_MAX < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV_MAX) begin : g_bad_params
            $error("display_scan_counter: need DIV_MAX >= 2 and 0 <= BLANK_CYCLES < DIV_MAX");
        end
    endgenerate

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      idx_q;
    logic [1:0]      idx_d;
    logic [c_bw-1:0] blank_cnt_q;
    logic [c_bw-1:0] blank_cnt_d;
    logic            frame_done_q;
    logic            frame_done_d;
    logic            w_tick;
    logic            w_blank_done;
    logic [3:0]      w_lit;

    scan_prescaler #(
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

    // With no blanking configured the blank state still occupies one clock.
    assign w_blank_done = (BLANK_CYCLES == 0) || (blank_cnt_q == c_blank_last);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        blank_cnt_d  = blank_cnt_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d     = ST_BLANK;
            blank_cnt_d = '0;
        end else if (state_q == ST_BLANK) begin
            if (w_blank_done) begin
                state_d     = ST_SHOW;
                blank_cnt_d = '0;
            end else begin
                blank_cnt_d = blank_cnt_q + 1'b1;
            end
        end else if (w_tick) begin
            idx_d        = idx_q + 1'b1;
            state_d      = ST_BLANK;
            blank_cnt_d  = '0;
            frame_done_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            blank_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            blank_cnt_q  <= blank_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign w_lit          = (state_q == ST_SHOW) ? onehot4(idx_q) : 4'b0000;
    assign anode          = (ANODE_ACTIVE_LOW != 0) ? ~w_lit : w_lit;
    assign saida1Contador = idx_q[1];
    assign saida2Contador = idx_q[0];
    assign frame_done     = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_counter.sv
// ============================================================================
//  tb_display_scan_counter
//  Directed bench: active-low 2-clock-blank instance plus an active-high
//  zero-blank instance sharing clock, reset and enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       s1_a, s2_a, fd_a;
    logic       s1_b, s2_b, fd_b;
    logic [3:0] an_a, an_b;
    logic [1:0] idx_a, idx_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    assign idx_a = {s1_a, s2_a};
    assign idx_b = {s1_b, s2_b};

    display_scan_counter #(
        .DIV_MAX          (8),
        .BLANK_CYCLES     (2),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .enable         (en),
        .saida1Contador (s1_a),
        .saida2Contador (s2_a),
        .anode          (an_a),
        .frame_done     (fd_a)
    );

    display_scan_counter #(
        .DIV_MAX          (8),
        .BLANK_CYCLES     (0),
        .ANODE_ACTIVE_LOW (0)
    ) dut_hi (
        .clock          (clk),
        .reset          (rst),
        .enable         (en),
        .saida1Contador (s1_b),
        .saida2Contador (s2_b),
        .anode          (an_b),
        .frame_done     (fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_anode_a", {4'b0, an_a}, 8'b1111);
        chk("rst_idx_a",   {6'b0, idx_a}, 8'd0);
        chk("rst_fd_a",    {7'b0, fd_a}, 8'd0);
        chk("rst_anode_b", {4'b0, an_b}, 8'b0000);

        // Scenario 1: release and first digit slots
        rst = 1'b0;
        cyc = 0;
        chk("s1_c0_anode", {4'b0, an_a}, 8'b1111);
        chk("s1_c0_hi",    {4'b0, an_b}, 8'b0000);
        adv(1);
        chk("s1_c1_anode", {4'b0, an_a}, 8'b1111);
        chk("s1_c1_hi",    {4'b0, an_b}, 8'b0001);
        adv(1);
        chk("s1_c2_anode", {4'b0, an_a}, 8'b1110);
        chk("s1_c2_idx",   {6'b0, idx_a}, 8'd0);
        adv(5);
        chk("s1_c7_anode", {4'b0, an_a}, 8'b1110);
        chk("s1_c7_idx",   {6'b0, idx_a}, 8'd0);
        adv(1);
        chk("s1_c8_idx",   {6'b0, idx_a}, 8'd1);
        chk("s1_c8_anode", {4'b0, an_a}, 8'b1111);
        chk("s1_c8_hi",    {4'b0, an_b}, 8'b0000);
        adv(1);
        chk("s1_c9_anode", {4'b0, an_a}, 8'b1111);
        chk("s1_c9_hi",    {4'b0, an_b}, 8'b0010);
        chk("s1_c9_idx_hi", {6'b0, idx_b}, 8'd1);
        adv(1);
        chk("s1_c10_anode", {4'b0, an_a}, 8'b1101);

        // Scenario 2: full frame, single frame_done pulse at cycle 32
        for (int c = 11; c <= 40; c++) begin
            adv(1);
            chk("s2_fd",    {7'b0, fd_a}, {7'b0, (cyc == 32)});
            chk("s2_fd_hi", {7'b0, fd_b}, {7'b0, (cyc == 32)});
            if (cyc == 16) chk("s2_idx16", {6'b0, idx_a}, 8'd2);
            if (cyc == 24) chk("s2_idx24", {6'b0, idx_a}, 8'd3);
            if (cyc == 32) chk("s2_idx32", {6'b0, idx_a}, 8'd0);
            if (cyc == 40) chk("s2_idx40", {6'b0, idx_a}, 8'd1);
        end

        // Scenario 3: disable while showing digit 2
        adv(12);
        chk("s3_c52_idx",   {6'b0, idx_a}, 8'd2);
        chk("s3_c52_anode", {4'b0, an_a}, 8'b1011);
        en = 1'b0;
        adv(1);
        chk("s3_off_anode", {4'b0, an_a}, 8'b1111);
        chk("s3_off_idx",   {6'b0, idx_a}, 8'd2);
        for (int c = 0; c < 19; c++) begin
            adv(1);
            chk("s3_off_fd",    {7'b0, fd_a}, 8'd0);
            chk("s3_off_blank", {4'b0, an_a}, 8'b1111);
        end
        chk("s3_hold_idx", {6'b0, idx_a}, 8'd2);
        en = 1'b1;
        adv(1);
        chk("s3_re_c73", {4'b0, an_a}, 8'b1111);
        adv(1);
        chk("s3_re_c74", {4'b0, an_a}, 8'b1011);
        chk("s3_re_idx", {6'b0, idx_a}, 8'd2);

        // Scenario 4: async reset in the blank gap after moving to digit 3
        adv(2);
        chk("s4_c76_idx",   {6'b0, idx_a}, 8'd3);
        chk("s4_c76_anode", {4'b0, an_a}, 8'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("s4_async_idx",   {6'b0, idx_a}, 8'd0);
        chk("s4_async_anode", {4'b0, an_a}, 8'b1111);
        chk("s4_async_hi",    {4'b0, an_b}, 8'b0000);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        chk("s4_c0", {4'b0, an_a}, 8'b1111);
        adv(1);
        chk("s4_c1", {4'b0, an_a}, 8'b1111);
        adv(1);
        chk("s4_c2", {4'b0, an_a}, 8'b1110);
        adv(6);
        chk("s4_c8_idx",   {6'b0, idx_a}, 8'd1);
        chk("s4_c8_anode", {4'b0, an_a}, 8'b1111);
        adv(2);
        chk("s4_c10_anode", {4'b0, an_a}, 8'b1101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
